cascade_key_store: RTL
======================

// Module: cascade_key_store
// PURPOSE
// - Parametrised Bob-side key store for Cascade error reconciliation. Holds the sifted key as DEPTH words of WORD_W bits.
// - Loads the key as a word stream with a valid/ready handshake.
// - Applies single-bit corrections and shuffle / inverse-shuffle permutations, and tracks which permutation is currently applied.
// - Sits between the sifted-key buffer and the Cascade parity engine.
// PARAMETERS
// WORD_W    32   load/readback word width
// DEPTH     32   number of words; KEY_N = WORD_W*DEPTH, must be a power of two
// NUM_SETS  4    shuffle sets 1..NUM_SETS; set 1 = identity
// ADDR_W    $clog2(DEPTH)           word address width
// IDX_W     $clog2(WORD_W*DEPTH)    bit index width
// SET_W     3    width of set selector
// PORTS
// clk         in   1        system clock, rising edge
// rst_n       in   1        asynchronous active-low reset
// load_start  in   1        pulse: begin new key load at word 0
// load_valid  in   1        load word valid
// load_ready  out  1        store accepts load word (LOAD state)
// load_data   in   WORD_W   key word
// load_done   out  1        1-cycle pulse after last word accepted
// cmd_valid   in   1        permute command valid
// cmd_ready   out  1        command accepted when high (IDLE state)
// cmd_inv     in   1        0 = shuffle, 1 = inverse shuffle
// cmd_set     in   SET_W    shuffle set 1..NUM_SETS
// cmd_done    out  1        1-cycle pulse: permutation written
// cmd_err     out  1        1-cycle pulse: command rejected, key unchanged
// flip_en     in   1        toggle key bit flip_idx (honoured in IDLE only)
// flip_idx    in   IDX_W    bit to correct
// rd_addr     in   ADDR_W   readback word address
// rd_data     out  WORD_W   registered readback, 1-cycle latency
// cur_set     out  SET_W    set currently applied to key (1 = natural order)
// key_out     out  KEY_N    full key vector (registered)
// BEHAVIOUR
// - Reset: async to all registers.
//   - key_out = 0, rd_data = 0, cur_set = 1.
//   - All pulses = 0; state = IDLE.
// - States: IDLE, LOAD, PERM.
// - IDLE:
//   - cmd_ready = 1, load_ready = 0.
//   - load_start -> LOAD; word counter = 0; cur_set = 1. load_start has priority over cmd_valid and flip_en.
//   - cmd_valid -> legality check:
//     - Shuffle is legal only when cur_set == 1 and 2 <= cmd_set <= NUM_SETS.
//     - Inverse is legal only when cmd_set == cur_set and cur_set != 1.
//     - Legal -> PERM. Illegal -> cmd_err pulse next cycle, stay in IDLE.
//   - flip_en with no command in the same cycle: key_out[flip_idx] toggled next cycle.
//     - Index is in permuted order, i.e. the current key_out bit position.
//     - flip_en together with cmd_valid: command wins, flip dropped.
// - LOAD:
//   - load_ready = 1. Each valid&&ready writes word[cnt] and increments cnt.
//   - Word at cnt == DEPTH-1: load_done pulse, cnt wraps to 0, -> IDLE.
//   - load_start in LOAD restarts at word 0. Words already written persist until overwritten.
//   - cmd_valid and flip_en are ignored.
// - PERM:
//   - One cycle. key_out <= permuted key from the sub-module.
//   - cur_set <= cmd_set for a shuffle, 1 for an inverse.
//   - cmd_done pulses; -> IDLE.
//   - Total latency: cmd accept -> key updated and cmd_done 2 cycles later.
// - Permutation, set s >= 2, KEY_N bits, M_s = 4s+1 (odd, so bijective mod KEY_N):
//   - Shuffle: out[(j*M_s + s) mod KEY_N] = in[j].
//   - Inverse: out[j] = in[(j*M_s + s) mod KEY_N].
//   - Products are computed at IDX_W+4 bits and truncated to IDX_W bits.
// - rd_data <= key_out[rd_addr*WORD_W +: WORD_W] every cycle; reflects the value before that cycle's write.
// - Reset mid-LOAD or mid-PERM: everything returns to the reset values; no partial pulses.
// STRUCTURE
// - Shared parameter include holds:
//   - State encodings IDLE = 2'd0, LOAD = 2'd1, PERM = 2'd2.
//   - Default WORD_W/DEPTH/NUM_SETS.
//   - Multiplier function M_s = 4s+1.
// - Sub-module key_permute_net (combinational, params KEY_N, NUM_SETS):
//   - Inputs: key_in, set, inv. Output: key_perm.
//   - Generate loops over the sets and a mux on set/inv.
// - Top level: FSM, load counter, flip decoder, readback register.
// TESTING
// - Reset, then load 32 words 0x00000000..0x0000001F with load_valid held high.
//   -> load_ready high for 32 cycles; load_done pulses once.
//   -> rd_addr = 5 gives rd_data = 0x5 one cycle later.
// - Load all zeros, flip_idx = 0, then cmd shuffle set 2.
//   -> cmd_done 2 cycles after accept; key_out has only bit 2 set; cur_set = 2.
// - From the previous state, inverse set 2.
//   -> key_out bit 0 only; cur_set = 1.
//   -> Random key: shuffle s then inverse s restores the original, for s = 2..4.
// - With cur_set = 2: shuffle set 3, then inverse set 4, then cmd_set = 5.
//   -> cmd_err pulse for each; key_out and cur_set unchanged.
// - flip_en and cmd_valid in the same IDLE cycle -> only the permutation applied.
//   flip_en during LOAD -> ignored.
// - Deassert rst_n mid-LOAD (word 10) and mid-PERM.
//   -> key_out = 0, cur_set = 1, state IDLE, load_ready = 0, no load_done/cmd_done pulse.

Source files
------------

// File: rtl/cascade_key_store_pkg.sv
// Shared definitions for the Cascade key store: state encoding, default
// geometry and the per-set shuffle multiplier.
package cascade_key_store_pkg;

  localparam int DEF_WORD_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_SETS = 4;
  localparam int DEF_SET_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PERM = 2'd2
  } state_t;

  // Odd multiplier, so j -> j*M+s is a bijection modulo any power of two.
  function automatic int perm_mult(input int s);
    return 4 * s + 1;
  endfunction

endpackage

// File: rtl/cascade_key_store_permute_net.sv
// Combinational shuffle / inverse-shuffle network for every set 2..NUM_SETS,
// muxed on set and inv; set 1 or an out-of-range set passes the key through.
module key_permute_net
  import cascade_key_store_pkg::*;
#(
  parameter int KEY_N    = 1024,
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int SET_W    = DEF_SET_W
) (
  input  logic [KEY_N-1:0] key_in,
  input  logic [SET_W-1:0] set,
  input  logic             inv,
  output logic [KEY_N-1:0] key_perm
);

  localparam int IDX_W = $clog2(KEY_N);
  localparam int PRD_W = IDX_W + 4;

  logic [KEY_N-1:0] fwd_arr [2:NUM_SETS];
  logic [KEY_N-1:0] inv_arr [2:NUM_SETS];

  for (genvar s = 2; s <= NUM_SETS; s++) begin : g_set
    logic [KEY_N-1:0] fwd;
    logic [KEY_N-1:0] bwd;

    // Index arithmetic is done wide and truncated, which is mod KEY_N.
    always_comb begin
      logic [PRD_W-1:0] prod;
      logic [IDX_W-1:0] pos;
      prod = '0;
      pos  = '0;
      fwd  = '0;
      bwd  = '0;
      for (int j = 0; j < KEY_N; j++) begin
        prod     = PRD_W'(j) * PRD_W'(perm_mult(s)) + PRD_W'(s);
        pos      = prod[IDX_W-1:0];
        fwd[pos] = key_in[j];
        bwd[j]   = key_in[pos];
      end
    end

    assign fwd_arr[s] = fwd;
    assign inv_arr[s] = bwd;
  end

  always_comb begin
    key_perm = key_in;
    for (int s = 2; s <= NUM_SETS; s++) begin
      if (set == SET_W'(s)) key_perm = inv ? inv_arr[s] : fwd_arr[s];
    end
  end

endmodule

// File: rtl/cascade_key_store.sv
// Bob-side Cascade key store: streamed key load, single-bit corrections and
// shuffle / inverse-shuffle permutations with tracking of the applied set.
//
// state | meaning
// IDLE  | accepts load_start, permute commands and bit flips
// LOAD  | writes one key word per valid&&ready beat, word 0 upward
// PERM  | one cycle: key replaced by the permuted key, cmd_done pulses
module cascade_key_store
  import cascade_key_store_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int IDX_W    = $clog2(WORD_W * DEPTH),
  parameter int SET_W    = DEF_SET_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [WORD_W-1:0]         load_data,
  output logic                      load_done,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_inv,
  input  logic [SET_W-1:0]          cmd_set,
  output logic                      cmd_done,
  output logic                      cmd_err,
  input  logic                      flip_en,
  input  logic [IDX_W-1:0]          flip_idx,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WORD_W-1:0]         rd_data,
  output logic [SET_W-1:0]          cur_set,
  output logic [WORD_W*DEPTH-1:0]   key_out
);

  localparam int KEY_N = WORD_W * DEPTH;
  localparam logic [SET_W-1:0] SET_NAT = SET_W'(1);

  state_t            state_q, state_d;
  logic [KEY_N-1:0]  key_q, key_d, key_perm;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0]  cur_set_q, cur_set_d;
  logic [SET_W-1:0]  cmd_set_q, cmd_set_d;
  logic              cmd_inv_q, cmd_inv_d;
  logic              load_done_q, load_done_d;
  logic              cmd_done_q, cmd_done_d;
  logic              cmd_err_q, cmd_err_d;
  logic [WORD_W-1:0] rd_data_q;
  logic              shuf_ok, inv_ok, cmd_legal;

  key_permute_net #(
    .KEY_N    (KEY_N),
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W)
  ) u_permute (
    .key_in   (key_q),
    .set      (cmd_set_q),
    .inv      (cmd_inv_q),
    .key_perm (key_perm)
  );

  // A shuffle is only applied to a naturally ordered key; an inverse only
  // undoes the set that is currently applied.
  assign shuf_ok   = (cur_set_q == SET_NAT) && (cmd_set >= SET_W'(2)) &&
                     (cmd_set <= SET_W'(NUM_SETS));
  assign inv_ok    = (cmd_set == cur_set_q) && (cur_set_q != SET_NAT);
  assign cmd_legal = cmd_inv ? inv_ok : shuf_ok;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    cur_set_d   = cur_set_q;
    cmd_set_d   = cmd_set_q;
    cmd_inv_d   = cmd_inv_q;
    load_done_d = 1'b0;
    cmd_done_d  = 1'b0;
    cmd_err_d   = 1'b0;
    load_ready  = 1'b0;
    cmd_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (load_start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          cur_set_d = SET_NAT;
        end else if (cmd_valid) begin
          if (cmd_legal) begin
            state_d   = ST_PERM;
            cmd_set_d = cmd_set;
            cmd_inv_d = cmd_inv;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else if (flip_en) begin
          key_d[flip_idx] = ~key_q[flip_idx];
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_start) begin
          cnt_d = '0;
        end else if (load_valid) begin
          key_d[int'(cnt_q)*WORD_W +: WORD_W] = load_data;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            cnt_d       = '0;
            load_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PERM: begin
        key_d      = key_perm;
        cur_set_d  = cmd_inv_q ? SET_NAT : cmd_set_q;
        cmd_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      cur_set_q   <= SET_NAT;
      cmd_set_q   <= SET_NAT;
      cmd_inv_q   <= 1'b0;
      load_done_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      cur_set_q   <= cur_set_d;
      cmd_set_q   <= cmd_set_d;
      cmd_inv_q   <= cmd_inv_d;
      load_done_q <= load_done_d;
      cmd_done_q  <= cmd_done_d;
      cmd_err_q   <= cmd_err_d;
      rd_data_q   <= key_q[int'(rd_addr)*WORD_W +: WORD_W];
    end
  end

  assign key_out   = key_q;
  assign cur_set   = cur_set_q;
  assign load_done = load_done_q;
  assign cmd_done  = cmd_done_q;
  assign cmd_err   = cmd_err_q;
  assign rd_data   = rd_data_q;

endmodule
